// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the immediate field of a 32-bit RISC-V instruction word into an
//   XLEN-wide sign- or zero-extended value.
//   The result is registered behind a 2-entry skid buffer (main + skid), so
//   there is one cycle of latency and a fully registered in_ready.
//
// Optional feature macro: IMM_GEN_ZIMM_EN
//   When defined, ImmSrc 3'b101 decodes the CSR zimm field
//   (zero-extended data_in[19:15]).
//   When not defined, ImmSrc 3'b101 is flagged as illegal.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready = !skid_valid, registered)
//   ImmSrc, data_in, tag_in   format select, instruction word, sideband tag
//   flush                     synchronous drop of every held entry
//   out_valid / out_ready     downstream handshake
//   data_out, tag_out         immediate and tag, driven straight from the main register
//   illegal                   main entry had an unsupported ImmSrc
//   illegal_cnt               saturating count of accepted illegal entries
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ImmSrc,
   input  logic [31:0]      data_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  data_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             illegal,
   output logic [7:0]       illegal_cnt
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } entry_t;

   entry_t     main_q, main_d, skid_q, skid_d, new_e;
   logic       main_vld, main_vld_d, skid_vld, skid_vld_d;
   logic       in_ready_q;
   logic [7:0] cnt_q, cnt_d;
   logic [31:0] imm32;
   logic       accept, drain;

   // Opcode bits never contribute to any immediate.
   logic unused_opcode;
   assign unused_opcode = ^data_in[6:0];

   // Decode to 32 bits first; the result is then extended from bit 31.
   // Doing it this way avoids zero-width replications when XLEN == 32.
   // zimm and the illegal encodings keep bit 31 at 0, so they extend with zeros.
   always_comb begin
      imm32     = '0;
      new_e.ill = 1'b0;
      case (ImmSrc)
         3'b000: imm32 = {{20{data_in[31]}}, data_in[31:20]};
         3'b001: imm32 = {{20{data_in[31]}}, data_in[31:25], data_in[11:7]};
         3'b010: imm32 = {{20{data_in[31]}}, data_in[7], data_in[30:25],
                          data_in[11:8], 1'b0};
         3'b011: imm32 = {{12{data_in[31]}}, data_in[19:12], data_in[20],
                          data_in[30:21], 1'b0};
         3'b100: imm32 = {data_in[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
         3'b101: imm32 = {27'b0, data_in[19:15]};
`else
         3'b101: new_e.ill = 1'b1;
`endif
         default: new_e.ill = 1'b1;
      endcase
      new_e.imm        = {XLEN{imm32[31]}};
      new_e.imm[31:0]  = imm32;
      new_e.tag        = tag_in;
   end

   assign accept = in_valid & in_ready_q;
   assign drain  = main_vld & out_ready;

   // Skid can only be occupied while main is.
   // While skid is occupied, in_ready is low, so accept and a skid-to-main
   // move never happen in the same cycle.
   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld;
      skid_d     = skid_q;
      skid_vld_d = skid_vld;
      cnt_d      = cnt_q;
      if (flush) begin
         // Flush wins over a same-cycle accept: the input is dropped and is not counted.
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (drain) begin
            if (skid_vld) begin
               main_d     = skid_q;
               main_vld_d = 1'b1;
               skid_vld_d = 1'b0;
            end else if (accept) begin
               main_d     = new_e;
               main_vld_d = 1'b1;
            end else begin
               main_vld_d = 1'b0;
            end
         end else if (accept) begin
            if (main_vld) begin
               skid_d     = new_e;
               skid_vld_d = 1'b1;
            end else begin
               main_d     = new_e;
               main_vld_d = 1'b1;
            end
         end
         if (accept && new_e.ill && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld   <= 1'b0;
         skid_vld   <= 1'b0;
         in_ready_q <= 1'b1;
         cnt_q      <= 8'd0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld   <= main_vld_d;
         skid_vld   <= skid_vld_d;
         in_ready_q <= ~skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_vld;
   assign data_out    = main_q.imm;
   assign tag_out     = main_q.tag;
   assign illegal     = main_q.ill;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe (XLEN=32, TAG_W=5).
// Every expected value below is worked out by hand from the instruction encodings.
module tb_imm_gen_pipe;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk, rst;
   logic             in_valid, in_ready;
   logic [2:0]       ImmSrc;
   logic [31:0]      data_in;
   logic [TAG_W-1:0] tag_in;
   logic             flush;
   logic             out_valid, out_ready;
   logic [XLEN-1:0]  data_out;
   logic [TAG_W-1:0] tag_out;
   logic             illegal;
   logic [7:0]       illegal_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   logic [7:0] cnt_snap;

   imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ImmSrc(ImmSrc), .data_in(data_in), .tag_in(tag_in),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .tag_out(tag_out),
      .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single transfer with out_ready high; the result must appear one edge later.
   task automatic send(input string tag, input logic [2:0] src, input logic [31:0] d,
                       input logic [4:0] t, input logic [31:0] exp, input logic exp_ill);
      in_valid = 1'b1; ImmSrc = src; data_in = d; tag_in = t;
      step();
      in_valid = 1'b0;
      if (exp_ill && exp_cnt < 255) exp_cnt++;
      chk({tag, ".vld"}, 64'(out_valid), 64'd1);
      chk({tag, ".data"}, 64'(data_out), 64'(exp));
      chk({tag, ".tag"}, 64'(tag_out), 64'(t));
      chk({tag, ".ill"}, 64'(illegal), 64'(exp_ill));
      chk({tag, ".cnt"}, 64'(illegal_cnt), 64'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; ImmSrc = 3'b0; data_in = '0; tag_in = '0;
      flush = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.data", 64'(data_out), 64'd0);
      chk("rst.tag", 64'(tag_out), 64'd0);
      chk("rst.ill", 64'(illegal), 64'd0);
      chk("rst.cnt", 64'(illegal_cnt), 64'd0);
      rst = 1'b0;
      step();

      // Decode vectors
      out_ready = 1'b1;
      send("I_neg", 3'b000, 32'hFFF00093, 5'd7,  32'hFFFFFFFF, 1'b0);
      send("I_pos", 3'b000, 32'h7FF00013, 5'd8,  32'h000007FF, 1'b0);
      send("S_neg", 3'b001, 32'h80000F80, 5'd9,  32'hFFFFF81F, 1'b0);
      send("B",     3'b010, 32'hFE000EE3, 5'd10, 32'hFFFFFFFC, 1'b0);
      send("J",     3'b011, 32'hFF9FF06F, 5'd11, 32'hFFFFFFF8, 1'b0);
      send("U",     3'b100, 32'h123450B7, 5'd12, 32'h12345000, 1'b0);
      send("U_neg", 3'b100, 32'h80000037, 5'd13, 32'h80000000, 1'b0);
      send("ill110", 3'b110, 32'hFFFFFFFF, 5'd14, 32'h0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
      send("zimm", 3'b101, 32'h000F8073, 5'd15, 32'h0000001F, 1'b0);
`else
      send("zimm_ill", 3'b101, 32'h000F8073, 5'd15, 32'h0, 1'b1);
`endif
      step();
      chk("idle.out_valid", 64'(out_valid), 64'd0);

      // Backpressure: entries 1 and 2 fill main and skid, and entry 3 has to wait.
      out_ready = 1'b0;
      in_valid = 1'b1; ImmSrc = 3'b000; data_in = 32'h00100013; tag_in = 5'd1;
      step();
      chk("bp1.in_ready", 64'(in_ready), 64'd1);
      chk("bp1.tag", 64'(tag_out), 64'd1);
      tag_in = 5'd2; data_in = 32'h00200013;
      step();
      chk("bp2.in_ready", 64'(in_ready), 64'd0);
      chk("bp2.tag", 64'(tag_out), 64'd1);
      tag_in = 5'd3; data_in = 32'h00300013;
      step();
      chk("bp3.hold_vld", 64'(out_valid), 64'd1);
      chk("bp3.hold_tag", 64'(tag_out), 64'd1);
      chk("bp3.hold_data", 64'(data_out), 64'd1);
      out_ready = 1'b1;
      step();
      chk("rel1.tag", 64'(tag_out), 64'd2);
      chk("rel1.data", 64'(data_out), 64'd2);
      chk("rel1.in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("rel2.tag", 64'(tag_out), 64'd3);
      chk("rel2.data", 64'(data_out), 64'd3);
      step();
      chk("rel3.empty", 64'(out_valid), 64'd0);

      // Flush while skid is full and an illegal input is being presented.
      out_ready = 1'b0;
      in_valid = 1'b1; ImmSrc = 3'b000; data_in = 32'h00400013; tag_in = 5'd4;
      step();
      tag_in = 5'd5;
      step();
      chk("fl.full", 64'(in_ready), 64'd0);
      cnt_snap = illegal_cnt;
      flush = 1'b1; ImmSrc = 3'b111; tag_in = 5'd6;
      step();
      chk("fl.out_valid", 64'(out_valid), 64'd0);
      chk("fl.in_ready", 64'(in_ready), 64'd1);
      chk("fl.cnt", 64'(illegal_cnt), 64'(cnt_snap));
      // A second flush while empty (in_ready high) must still drop the illegal input.
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl2.out_valid", 64'(out_valid), 64'd0);
      chk("fl2.cnt", 64'(illegal_cnt), 64'(cnt_snap));

      // Saturation of illegal_cnt over 300 accepted illegal entries.
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1; ImmSrc = 3'b111; data_in = 32'hFFFFFFFF; tag_in = 5'(i);
         step();
         if (exp_cnt < 255) exp_cnt++;
         chk("sat.data", 64'(data_out), 64'd0);
         chk("sat.ill", 64'(illegal), 64'd1);
         if (i == 9) chk("sat.cnt10", 64'(illegal_cnt), 64'(exp_cnt));
      end
      in_valid = 1'b0;
      chk("sat.cnt", 64'(illegal_cnt), 64'd255);

      // Reset in the middle of a transfer drops everything held.
      out_ready = 1'b0;
      in_valid = 1'b1; ImmSrc = 3'b000; data_in = 32'h00500013; tag_in = 5'd20;
      step();
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mrst.out_valid", 64'(out_valid), 64'd0);
      chk("mrst.in_ready", 64'(in_ready), 64'd1);
      chk("mrst.cnt", 64'(illegal_cnt), 64'd0);
      chk("mrst.data", 64'(data_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      step();
      out_ready = 1'b1;
      send("post_rst", 3'b000, 32'h7FF00013, 5'd21, 32'h000007FF, 1'b0);
      step();
      chk("post_rst.empty", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning output immediate width; legal values 32 or 64.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning sideband tag width (e.g. rd index) carried alongside each immediate.
REQ-003 Port clk  input  1  The block SHALL use this single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  The block SHALL treat this as the reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  The block SHALL treat this as the upstream instruction-valid flag.
REQ-006 Port in_ready  output  1  The block SHALL drive this high when it can accept an input this cycle.
REQ-007 Port ImmSrc  input  3  The block SHALL treat this as the immediate format select.
REQ-008 Port data_in  input  32  The block SHALL treat this as the raw instruction word.
REQ-009 Port tag_in  input  TAG_W  The block SHALL treat this as the sideband tag.
REQ-010 Port flush  input  1  The block SHALL treat this as a synchronous pipeline flush.
REQ-011 Port out_valid  output  1  The block SHALL drive this high when the output holds a valid result.
REQ-012 Port out_ready  input  1  The block SHALL treat this as downstream acceptance.
REQ-013 Port data_out  output  XLEN  The block SHALL drive the extended immediate on this port.
REQ-014 Port tag_out  output  TAG_W  The block SHALL drive the tag paired with data_out on this port.
REQ-015 Port illegal  output  1  The block SHALL drive this high with out_valid when the entry had an unsupported ImmSrc.
REQ-016 Port illegal_cnt  output  8  The block SHALL drive the saturating count of accepted illegal entries on this port.

Function
REQ-017 Decode SHALL be (bits of data_in, sign = data_in[31] replicated to XLEN): 000 I {sign,[31:20]}; 001 S {sign,[31:25],[11:7]}; 010 B {sign,[7],[30:25],[11:8],0}; 011 J {sign,[19:12],[20],[30:21],0}; 100 U {sign to XLEN-32 bits,[31:12],12'b0}.
REQ-018 Encodings 101 (when the macro is absent), 110 and 111 SHALL produce data_out = 0 and illegal = 1.
REQ-019 Transfers SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-020 Storage SHALL be a 2-entry skid buffer (main + skid); data_out/tag_out/illegal SHALL come straight from the main register.
REQ-021 in_ready SHALL be registered and equal to NOT skid_valid.
REQ-022 Latency SHALL be 1 cycle: an input accepted at edge N SHALL be visible on out_valid after edge N when main is empty or draining at edge N.
REQ-023 An accept while main is full and not draining SHALL load skid; when main drains, skid SHALL move to main at that edge and skid_valid SHALL clear.
REQ-024 Simultaneous accept and drain with skid empty SHALL load main directly; order SHALL always be preserved.
REQ-025 Output signals SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL clear main and skid valid at the next edge, dominate a simultaneous accept (input dropped, not counted), and leave illegal_cnt unchanged.
REQ-027 illegal_cnt SHALL increment on each accepted illegal entry and saturate at 255.

Reset
REQ-028 On rst: out_valid=0, in_ready=1, skid_valid=0, data_out=0, tag_out=0, illegal=0, illegal_cnt=0, asynchronously.
REQ-029 A reset asserted mid-transfer SHALL discard all held entries; the first accept after release SHALL behave as from empty.

Configuration
REQ-030 With macro IMM_GEN_ZIMM_EN defined, ImmSrc 101 SHALL be legal CSR zimm: data_out = zero-extended data_in[19:15], illegal = 0.
REQ-031 Without IMM_GEN_ZIMM_EN, ImmSrc 101 SHALL be illegal per REQ-018.

Verification
REQ-032 I-type: data_in=0xFFF00093, ImmSrc=000, out_ready=1 -> next cycle data_out=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF).
REQ-033 B/J: 0xFE000EE3 with 010 -> 0xFFFFFFFC; 0xFF9FF06F with 011 -> 0xFFFFFFF8; U 0x123450B7 with 100 -> 0x12345000.
REQ-034 Backpressure: out_ready=0, three back-to-back inputs with tags 1,2,3 -> in_ready low after the second; release yields tags 1,2 in order, the third only after re-accept.
REQ-035 Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
REQ-036 Illegal: ImmSrc=111 for 300 accepts -> data_out=0, illegal=1 each, illegal_cnt=255; ImmSrc=101, data_in[19:15]=5'h1F -> 0x1F only with IMM_GEN_ZIMM_EN.
